// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one alu through round-robin arbitration.
// The result of the accepted operation is registered and returned, tagged with
// the requester id, over a valid/ready response channel.
//
// Operation encoding used by the internal alu (unit / op):
//   00 adder   : op[3]=0 ADD, op[3]=1 SUB (wraps modulo 2^OL)
//   01 logic   : 0100 XOR, 0110 OR, 0111 AND, others 0
//   10 shifter : 0011 SLL, 0101 SRL, 1101 SRA (amount = low log2(OL) bits of b), others 0
//   11 compare : 0000 EQ, 0001 NE, 0100 LT, 0101 GE, 0110 GEU, 0111 LTU, others 0
//                result is 0 or 1, zero-extended to OL bits

module alu #(
  parameter int OPERAND_LENGTH = 8
) (
  input  logic [OPERAND_LENGTH-1:0] opd1,
  input  logic [OPERAND_LENGTH-1:0] opd2,
  input  logic [OPERAND_LENGTH-1:0] opd3,
  input  logic [OPERAND_LENGTH-1:0] opd4,
  input  logic                      alu_mux1_select,
  input  logic [1:0]                alu_mux2_select,
  input  logic [3:0]                alu_op_select,
  output logic [OPERAND_LENGTH-1:0] alu_result,
  output logic [OPERAND_LENGTH-1:0] comp_result
);
  localparam int OL = OPERAND_LENGTH;
  localparam int SW = (OL > 1) ? $clog2(OL) : 1;

  // mux1 picks which operand pair feeds the arithmetic units
  logic [OL-1:0]        opx, opy;
  logic signed [OL-1:0] opx_s;
  logic [SW-1:0]        sh;
  logic [OL-1:0]        add_res, log_res, shf_res;
  logic                 cmp_bit;

  assign opx   = alu_mux1_select ? opd3 : opd1;
  assign opy   = alu_mux1_select ? opd4 : opd2;
  assign opx_s = opx;
  assign sh    = opy[SW-1:0];

  // adder: bit 3 of the op selects subtraction
  always_comb begin
    add_res = alu_op_select[3] ? (opx - opy) : (opx + opy);
  end

  // bitwise logic unit
  always_comb begin
    log_res = '0;
    case (alu_op_select)
      4'b0100: log_res = opx ^ opy;
      4'b0110: log_res = opx | opy;
      4'b0111: log_res = opx & opy;
      default: log_res = '0;
    endcase
  end

  // barrel shifter; SRA replicates the sign of the first operand
  always_comb begin
    shf_res = '0;
    case (alu_op_select)
      4'b0011: shf_res = opx << sh;
      4'b0101: shf_res = opx >> sh;
      4'b1101: shf_res = opx_s >>> sh;
      default: shf_res = '0;
    endcase
  end

  // comparator always works on the second operand pair
  always_comb begin
    cmp_bit = 1'b0;
    case (alu_op_select)
      4'b0000: cmp_bit = (opd3 == opd4);
      4'b0001: cmp_bit = (opd3 != opd4);
      4'b0100: cmp_bit = ($signed(opd3) <  $signed(opd4));
      4'b0101: cmp_bit = ($signed(opd3) >= $signed(opd4));
      4'b0110: cmp_bit = (opd3 >= opd4);
      4'b0111: cmp_bit = (opd3 <  opd4);
      default: cmp_bit = 1'b0;
    endcase
  end

  assign comp_result = {{(OL-1){1'b0}}, cmp_bit};

  // mux2 selects the unit whose output appears on alu_result
  always_comb begin
    alu_result = add_res;
    case (alu_mux2_select)
      2'b00:   alu_result = add_res;
      2'b01:   alu_result = log_res;
      2'b10:   alu_result = shf_res;
      default: alu_result = comp_result;
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int OPERAND_LENGTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [OPERAND_LENGTH-1:0] req0_opd_a,
  input  logic [OPERAND_LENGTH-1:0] req0_opd_b,
  input  logic [1:0]                req0_unit,
  input  logic [3:0]                req0_op,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [OPERAND_LENGTH-1:0] req1_opd_a,
  input  logic [OPERAND_LENGTH-1:0] req1_opd_b,
  input  logic [1:0]                req1_unit,
  input  logic [3:0]                req1_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_id,
  output logic [OPERAND_LENGTH-1:0] rsp_data
);
  localparam int OL = OPERAND_LENGTH;

  logic          last_grant;
  logic          grant_any, grant_id;
  logic          slot_free, fire;
  logic [OL-1:0] sel_a, sel_b;
  logic [1:0]    sel_unit;
  logic [3:0]    sel_op;
  logic [OL-1:0] alu_result, comp_result, result;

  // round-robin: a contested cycle goes to whoever did not win last time;
  // with no request grant_id stays 0 so requester 0 fields drive the alu
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
  end

  // the response register can take a new result when empty or being drained
  assign slot_free  = ~rsp_valid | rsp_ready;
  assign fire       = grant_any & slot_free & rst_n;
  assign req0_ready = grant_any & ~grant_id & slot_free & rst_n;
  assign req1_ready = grant_any &  grant_id & slot_free & rst_n;

  // route the granted requester's fields to the alu
  always_comb begin
    sel_a    = grant_id ? req1_opd_a : req0_opd_a;
    sel_b    = grant_id ? req1_opd_b : req0_opd_b;
    sel_unit = grant_id ? req1_unit  : req0_unit;
    sel_op   = grant_id ? req1_op    : req0_op;
  end

  alu #(.OPERAND_LENGTH(OL)) u_alu (
    .opd1            (sel_a),
    .opd2            (sel_b),
    .opd3            (sel_a),
    .opd4            (sel_b),
    .alu_mux1_select (1'b0),
    .alu_mux2_select (sel_unit),
    .alu_op_select   (sel_op),
    .alu_result      (alu_result),
    .comp_result     (comp_result)
  );

  assign result = (sel_unit == 2'b11) ? comp_result : alu_result;

  // response register and round-robin pointer; a new accept overwrites a
  // draining result, a drain without accept only clears valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      last_grant <= 1'b1;
    end else if (fire) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= grant_id;
      rsp_data   <= result;
      last_grant <= grant_id;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed cases with literal expectations, then
// randomized requests/backpressure/reset pulses checked each cycle against a
// behavioural model of the arbiter and alu.

module tb_alu_arbiter;
  localparam int OL = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [OL-1:0] req0_opd_a, req0_opd_b, req1_opd_a, req1_opd_b;
  logic [1:0]    req0_unit, req1_unit;
  logic [3:0]    req0_op, req1_op;
  logic          rsp_valid, rsp_ready, rsp_id;
  logic [OL-1:0] rsp_data;

  always #5 clk = ~clk;

  alu_arbiter #(.OPERAND_LENGTH(OL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opd_a(req0_opd_a),
    .req0_opd_b(req0_opd_b), .req0_unit(req0_unit), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opd_a(req1_opd_a),
    .req1_opd_b(req1_opd_b), .req1_unit(req1_unit), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic          m_valid = 1'b0;
  logic          m_id    = 1'b0;
  logic          m_last  = 1'b1;
  logic [OL-1:0] m_data  = '0;

  logic hs0 = 1'b0, hs1 = 1'b0;

  logic [5:0] op_tab [0:13] = '{6'h00, 6'h08, 6'h14, 6'h16, 6'h17, 6'h23, 6'h25,
                                6'h2D, 6'h30, 6'h31, 6'h34, 6'h35, 6'h36, 6'h37};

  // expected alu output from plain integer arithmetic
  function automatic logic [7:0] ref_result(input logic [1:0] unit, input logic [3:0] op,
                                            input logic [7:0] a, input logic [7:0] b);
    int ia, ib, sa, sb, sh, v;
    ia = {24'd0, a};
    ib = {24'd0, b};
    sa = ia - (a[7] ? 256 : 0);
    sb = ib - (b[7] ? 256 : 0);
    sh = ib % 8;
    v  = 0;
    case (unit)
      2'd0: v = op[3] ? ia - ib : ia + ib;
      2'd1: case (op)
              4'd4: v = ia ^ ib;
              4'd6: v = ia | ib;
              4'd7: v = ia & ib;
              default: v = 0;
            endcase
      2'd2: case (op)
              4'd3:  v = ia << sh;
              4'd5:  v = ia >> sh;
              4'd13: v = sa >>> sh;
              default: v = 0;
            endcase
      default: case (op)
              4'd0: v = (ia == ib) ? 1 : 0;
              4'd1: v = (ia != ib) ? 1 : 0;
              4'd4: v = (sa <  sb) ? 1 : 0;
              4'd5: v = (sa >= sb) ? 1 : 0;
              4'd6: v = (ia >= ib) ? 1 : 0;
              4'd7: v = (ia <  ib) ? 1 : 0;
              default: v = 0;
            endcase
    endcase
    return v[7:0];
  endfunction

  // who would be granted now: -1 none, else requester index
  function automatic int winner();
    if (req0_valid && req1_valid) return m_last ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  // behavioural model of the response register and round-robin history
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_id    <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b1;
    end else if ((!m_valid || rsp_ready) && winner() >= 0) begin
      m_valid <= 1'b1;
      m_id    <= (winner() == 1);
      m_last  <= (winner() == 1);
      m_data  <= (winner() == 1) ? ref_result(req1_unit, req1_op, req1_opd_a, req1_opd_b)
                                 : ref_result(req0_unit, req0_op, req0_opd_a, req0_opd_b);
    end else if (rsp_ready) begin
      m_valid <= 1'b0;
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // full output comparison against the model
  task automatic compare();
    logic slot;
    slot = !m_valid || rsp_ready;
    chk1("req0_ready", req0_ready, rst_n && slot && winner() == 0);
    chk1("req1_ready", req1_ready, rst_n && slot && winner() == 1);
    chk1("rsp_valid", rsp_valid, m_valid);
    chk1("rsp_id", rsp_id, m_id);
    chk8("rsp_data", rsp_data, m_data);
  endtask

  // one cycle: compare at the falling edge, then move to just after the rising edge
  task automatic tick();
    @(negedge clk);
    compare();
    hs0 = req0_valid & req0_ready;
    hs1 = req1_valid & req1_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] u, input logic [3:0] o);
    req0_valid = v; req0_opd_a = a; req0_opd_b = b; req0_unit = u; req0_op = o;
  endtask

  task automatic set1(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] u, input logic [3:0] o);
    req1_valid = v; req1_opd_a = a; req1_opd_b = b; req1_unit = u; req1_op = o;
  endtask

  task automatic rand_req(input int which);
    logic [5:0] e;
    e = op_tab[$urandom_range(0, 13)];
    if (which == 0) set0($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), e[5:4], e[3:0]);
    else            set1($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), e[5:4], e[3:0]);
  endtask

  initial begin
    set0(1'b0, 8'd0, 8'd0, 2'd0, 4'd0);
    set1(1'b0, 8'd0, 8'd0, 2'd0, 4'd0);
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // pin the model on a few known values
    chk8("ref_sub_wrap", ref_result(2'd0, 4'd8, 8'd10, 8'd12), 8'hFE);
    chk8("ref_sra", ref_result(2'd2, 4'd13, 8'h80, 8'd2), 8'hE0);
    chk8("ref_lt_signed", ref_result(2'd3, 4'd4, 8'hFF, 8'h01), 8'h01);

    // reset state, ready gated by reset
    set0(1'b1, 8'd3, 8'd8, 2'b00, 4'b0000);
    #1;
    chk1("reset_rsp_valid", rsp_valid, 1'b0);
    chk1("reset_rsp_id", rsp_id, 1'b0);
    chk8("reset_rsp_data", rsp_data, 8'h00);
    chk1("reset_req0_ready", req0_ready, 1'b0);
    rst_n = 1'b1;
    #1;

    // 1: req0 alone, ADD
    chk1("t1_ready", req0_ready, 1'b1);
    tick();
    chk1("t1_valid", rsp_valid, 1'b1);
    chk1("t1_id", rsp_id, 1'b0);
    chk8("t1_data", rsp_data, 8'h0B);
    req0_valid = 1'b0;

    // 2: req1 alone, SUB wraps, then AND
    set1(1'b1, 8'd10, 8'd12, 2'b00, 4'b1000);
    tick();
    chk1("t2_id", rsp_id, 1'b1);
    chk8("t2_sub", rsp_data, 8'hFE);
    set1(1'b1, 8'hCC, 8'hFF, 2'b01, 4'b0111);
    tick();
    chk8("t2_and", rsp_data, 8'hCC);
    req1_valid = 1'b0;

    // 3: both valid from reset, strict alternation
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    set0(1'b1, 8'd1, 8'd1, 2'b00, 4'b0000);
    set1(1'b1, 8'd2, 8'd2, 2'b00, 4'b0000);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk1("t3_req0_ready", req0_ready, i % 2 == 0);
      tick();
      chk1("t3_id", rsp_id, i % 2 == 1);
      chk8("t3_data", rsp_data, (i % 2 == 1) ? 8'd4 : 8'd2);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // 4: backpressure holds SLL result and blocks grants
    set0(1'b1, 8'h0F, 8'd3, 2'b10, 4'b0011);
    tick();
    req0_valid = 1'b0;
    rsp_ready = 1'b0;
    set1(1'b1, 8'd5, 8'd6, 2'b00, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk8("t4_hold_data", rsp_data, 8'h78);
      chk1("t4_hold_ready", req1_ready, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk1("t4_release_ready", req1_ready, 1'b1);
    tick();
    chk8("t4_next_data", rsp_data, 8'h0B);
    chk1("t4_next_id", rsp_id, 1'b1);
    req1_valid = 1'b0;

    // 5: compare unit
    set0(1'b1, 8'hFF, 8'hFC, 2'b11, 4'b0111);
    tick();
    chk8("t5_ltu", rsp_data, 8'h00);
    req0_op = 4'b0001;
    tick();
    chk8("t5_ne", rsp_data, 8'h01);

    // 6: reset with a held response and both requesting
    set0(1'b1, 8'd1, 8'd2, 2'b00, 4'b0000);
    tick();
    set1(1'b1, 8'd3, 8'd4, 2'b00, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    chk1("t6_valid_cleared", rsp_valid, 1'b0);
    chk8("t6_data_cleared", rsp_data, 8'h00);
    chk1("t6_ready_in_reset", req1_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    chk1("t6_first_grant0", req0_ready, 1'b1);
    chk1("t6_first_grant1", req1_ready, 1'b0);
    tick();
    chk1("t6_first_id", rsp_id, 1'b0);

    // randomized traffic against the model
    hs0 = 1'b1;
    hs1 = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!req0_valid || hs0) rand_req(0);
      if (!req1_valid || hs1) rand_req(1);
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
